store_trace_checker: RTL and testbench

- Synthesizable self-checking monitor for the multi-issue MIPS core; generalises the dual-port bench checker to NUM_LANES store ports.
- Holds an expected store trace (addr/data pairs) in an internal register array, loaded serially before the run.
- During a run it compares every retired store, in lane order, against the trace.
- Also detects the finish PC, gates the CPU clock-enable, and counts cycles and retired instructions for CPI.

---
 rtl/store_trace_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_store_trace_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_trace_checker.sv
// store_trace_checker: synthesizable store-trace monitor for a multi-issue core.
// An expected (addr, data) store trace is loaded serially while idle. During a
// run every retired store is compared, in lane order, against the trace. The
// checker also detects the finish PC, gates the CPU clock-enable and counts
// cycles and retired instructions.
// Optional build macro: STORE_TRACE_STOP_ON_ERR_EN ends the run on the first
// erroring store instead of only counting it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | trace may be loaded; CPU held; start begins a run
// RUN   | CPU enabled; stores checked; counters advance
// DONE  | run finished; pass valid; start returns to IDLE and clears trace

module store_trace_checker #(
    parameter int NUM_LANES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [ADDR_W-1:0]             load_addr,
    input  logic [DATA_W-1:0]             load_data,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             finish_pc,
    input  logic [NUM_LANES-1:0]          lane_retire,
    input  logic [NUM_LANES*ADDR_W-1:0]   lane_pc,
    input  logic [NUM_LANES-1:0]          st_en,
    input  logic [NUM_LANES*ADDR_W-1:0]   st_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   st_data,
    output logic                          cpu_run,
    output logic                          done,
    output logic                          pass,
    output logic [CNT_W-1:0]              cycle_cnt,
    output logic [CNT_W-1:0]              instr_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic                          overrun,
    output logic                          first_err_valid,
    output logic [$clog2(DEPTH)-1:0]      first_err_idx,
    output logic [CNT_W-1:0]              first_err_cycle
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int LCW   = $clog2(NUM_LANES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] trace_addr [DEPTH];
    logic [DATA_W-1:0] trace_data [DEPTH];
    logic [PTR_W-1:0]  load_cnt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] fin_pc;

    logic              pc_hit;
    logic              fin;
    logic              chk_en;
    logic              load_ok;

    logic [PTR_W-1:0]  ptr;
    logic              bad;
    logic [LCW-1:0]    st_err_num;
    logic              st_overrun;
    logic              st_first;
    logic [IDX_W-1:0]  st_first_idx;
    logic              err_hit;

    logic [LCW-1:0]    ret_num;
    logic [CNT_W-1:0]  cycle_nxt;
    logic [CNT_W:0]    instr_sum;
    logic [CNT_W-1:0]  instr_nxt;
    logic [CNT_W:0]    err_sum;
    logic [CNT_W-1:0]  err_nxt;
    logic              pass_nxt;

    // Finish detection: any lane presenting the latched finish PC, retired or not.
    always_comb begin
        pc_hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_pc[k*ADDR_W +: ADDR_W] == fin_pc) pc_hit = 1'b1;
        end
    end

    assign fin     = (state == ST_RUN) && pc_hit;
    assign chk_en  = (state == ST_RUN) && !fin;
    assign done    = (state == ST_DONE);
    assign load_ok = (state == ST_IDLE) && load_valid && !load_cnt[IDX_W];

    // Walk valid stores in lane order; each consumes the next trace slot until exhausted.
    always_comb begin
        ptr          = rd_ptr;
        bad          = 1'b0;
        st_err_num   = '0;
        st_overrun   = 1'b0;
        st_first     = 1'b0;
        st_first_idx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (chk_en && st_en[k]) begin
                bad = 1'b0;
                if (ptr >= load_cnt) begin
                    bad        = 1'b1;
                    st_overrun = 1'b1;
                end else if ((trace_addr[ptr[IDX_W-1:0]] != st_addr[k*ADDR_W +: ADDR_W]) ||
                             (trace_data[ptr[IDX_W-1:0]] != st_data[k*DATA_W +: DATA_W])) begin
                    bad = 1'b1;
                end
                if (bad) begin
                    if (!st_first) begin
                        st_first     = 1'b1;
                        // ptr can only reach DEPTH when the trace is full; report the last slot.
                        st_first_idx = ptr[IDX_W] ? {IDX_W{1'b1}} : ptr[IDX_W-1:0];
                    end
                    st_err_num = st_err_num + LCW'(1);
                end
                if (ptr < load_cnt) ptr = ptr + PTR_W'(1);
            end
        end
    end

    assign err_hit = (st_err_num != '0);

`ifdef STORE_TRACE_STOP_ON_ERR_EN
    assign cpu_run = chk_en && !err_hit;
`else
    assign cpu_run = chk_en;
`endif

    // Saturating next values for the run counters.
    always_comb begin
        ret_num = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            ret_num = ret_num + LCW'(lane_retire[k]);
        end
        cycle_nxt = (cycle_cnt == {CNT_W{1'b1}}) ? cycle_cnt : cycle_cnt + CNT_W'(1);
        instr_sum = {1'b0, instr_cnt} + {{(CNT_W+1-LCW){1'b0}}, ret_num};
        instr_nxt = instr_sum[CNT_W] ? {CNT_W{1'b1}} : instr_sum[CNT_W-1:0];
        err_sum   = {1'b0, err_cnt} + {{(CNT_W+1-LCW){1'b0}}, st_err_num};
        err_nxt   = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        pass_nxt  = (err_nxt == '0) && !(overrun || st_overrun) && (ptr == load_cnt);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (fin) state_nxt = ST_DONE;
`ifdef STORE_TRACE_STOP_ON_ERR_EN
                else if (err_hit) state_nxt = ST_DONE;
`endif
            end
            ST_DONE: if (start) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Trace storage; validity is tracked by load_cnt so the array needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && load_ok) begin
            trace_addr[load_cnt[IDX_W-1:0]] <= load_addr;
            trace_data[load_cnt[IDX_W-1:0]] <= load_data;
        end
    end

    // Control state, pointers, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            load_cnt        <= '0;
            rd_ptr          <= '0;
            fin_pc          <= '0;
            pass            <= 1'b0;
            cycle_cnt       <= '0;
            instr_cnt       <= '0;
            err_cnt         <= '0;
            overrun         <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_cycle <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (load_ok) load_cnt <= load_cnt + PTR_W'(1);
                    if (start) begin
                        fin_pc          <= finish_pc;
                        rd_ptr          <= '0;
                        pass            <= 1'b0;
                        cycle_cnt       <= '0;
                        instr_cnt       <= '0;
                        err_cnt         <= '0;
                        overrun         <= 1'b0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        first_err_cycle <= '0;
                    end
                end
                ST_RUN: begin
                    rd_ptr  <= ptr;
                    err_cnt <= err_nxt;
                    if (st_overrun) overrun <= 1'b1;
                    if (chk_en) begin
                        cycle_cnt <= cycle_nxt;
                        instr_cnt <= instr_nxt;
                    end
                    if (st_first && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= st_first_idx;
                        first_err_cycle <= cycle_cnt;
                    end
                    if (state_nxt == ST_DONE) pass <= pass_nxt;
                end
                ST_DONE: begin
                    if (start) begin
                        load_cnt <= '0;
                        pass     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_store_trace_checker.sv
// tb_store_trace_checker: directed checks of the store trace checker with
// hand-computed expectations (table-driven main run plus corner sequences).

module tb_store_trace_checker;

    localparam int NL    = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int CW    = 32;
    localparam logic [31:0] IPC0 = 32'h400;
    localparam logic [31:0] IPC1 = 32'h404;
    localparam logic [31:0] FPC  = 32'h3C;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 load_valid;
    logic [AW-1:0]        load_addr;
    logic [DW-1:0]        load_data;
    logic                 start;
    logic [AW-1:0]        finish_pc;
    logic [NL-1:0]        lane_retire;
    logic [NL*AW-1:0]     lane_pc;
    logic [NL-1:0]        st_en;
    logic [NL*AW-1:0]     st_addr;
    logic [NL*DW-1:0]     st_data;
    logic                 cpu_run;
    logic                 done;
    logic                 pass;
    logic [CW-1:0]        cycle_cnt;
    logic [CW-1:0]        instr_cnt;
    logic [CW-1:0]        err_cnt;
    logic                 overrun;
    logic                 first_err_valid;
    logic [$clog2(DEPTH)-1:0] first_err_idx;
    logic [CW-1:0]        first_err_cycle;

    int   n_total = 0;
    int   n_pass  = 0;
    logic run_before;

    typedef struct {
        logic [1:0]  ret;
        logic [1:0]  en;
        logic [31:0] a0, d0, a1, d1, pc0, pc1;
        logic        exp_run;
        logic        exp_done;
        logic [31:0] exp_err;
        logic [31:0] exp_cyc;
        logic [31:0] exp_ins;
    } vec_t;

    vec_t vecs [6];

    store_trace_checker #(
        .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .start(start), .finish_pc(finish_pc),
        .lane_retire(lane_retire), .lane_pc(lane_pc),
        .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
        .cpu_run(cpu_run), .done(done), .pass(pass),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .err_cnt(err_cnt),
        .overrun(overrun), .first_err_valid(first_err_valid),
        .first_err_idx(first_err_idx), .first_err_cycle(first_err_cycle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        load_valid  = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        start       = 1'b0;
        lane_retire = '0;
        st_en       = '0;
        st_addr     = '0;
        st_data     = '0;
        lane_pc     = {IPC1, IPC0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] fpc);
        @(negedge clk);
        start     = 1'b1;
        finish_pc = fpc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // One clock with the given lane inputs; cpu_run is sampled before the edge.
    task automatic step(input logic [1:0] ret, input logic [1:0] en,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic [31:0] pc0, input logic [31:0] pc1);
        @(negedge clk);
        lane_retire = ret;
        st_en       = en;
        st_addr     = {a1, a0};
        st_data     = {d1, d0};
        lane_pc     = {pc1, pc0};
        #1 run_before = cpu_run;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic load3();
        load(32'h50, 32'h7);
        load(32'h54, 32'h8);
        load(32'h58, 32'h9);
    endtask

    initial begin
        reset = 1'b1;
        finish_pc = '0;
        run_before = 1'b0;
        idle_inputs();

        vecs[0] = '{2'b11, 2'b00, 32'h0,  32'h0, 32'h0,  32'h0, IPC0, IPC1, 1'b1, 1'b0, 32'd0, 32'd1, 32'd2};
        vecs[1] = '{2'b01, 2'b01, 32'h50, 32'h7, 32'h0,  32'h0, IPC0, IPC1, 1'b1, 1'b0, 32'd0, 32'd2, 32'd3};
        vecs[2] = '{2'b00, 2'b00, 32'h0,  32'h0, 32'h0,  32'h0, IPC0, IPC1, 1'b1, 1'b0, 32'd0, 32'd3, 32'd3};
        vecs[3] = '{2'b11, 2'b11, 32'h54, 32'h8, 32'h58, 32'h9, IPC0, IPC1, 1'b1, 1'b0, 32'd0, 32'd4, 32'd5};
        vecs[4] = '{2'b10, 2'b00, 32'h0,  32'h0, 32'h0,  32'h0, IPC0, IPC1, 1'b1, 1'b0, 32'd0, 32'd5, 32'd6};
        vecs[5] = '{2'b11, 2'b01, 32'h99, 32'h1, 32'h0,  32'h0, IPC0, FPC,  1'b0, 1'b1, 32'd0, 32'd5, 32'd6};

        // Reset values
        do_reset();
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_counts", {cycle_cnt, instr_cnt | err_cnt}, 0);
        chk("rst_flags", {overrun, first_err_valid}, 0);

        // Scenario 1: table-driven clean run
        load3();
        pulse_start(FPC);
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].ret, vecs[i].en, vecs[i].a0, vecs[i].d0,
                 vecs[i].a1, vecs[i].d1, vecs[i].pc0, vecs[i].pc1);
            chk($sformatf("s1_run_%0d", i), run_before, vecs[i].exp_run);
            chk($sformatf("s1_done_%0d", i), done, vecs[i].exp_done);
            chk($sformatf("s1_err_%0d", i), err_cnt, vecs[i].exp_err);
            chk($sformatf("s1_cyc_%0d", i), cycle_cnt, vecs[i].exp_cyc);
            chk($sformatf("s1_ins_%0d", i), instr_cnt, vecs[i].exp_ins);
        end
        chk("s1_pass", pass, 1);
        chk("s1_overrun", overrun, 0);

        // DONE -> IDLE clears the trace; scenario 5 then runs with an empty trace
        pulse_start(FPC);
        chk("s1_back_idle", {done, cpu_run}, 0);

        // Scenario 5: instruction counting, store in fin cycle ignored, load during run ignored
        pulse_start(FPC);
        load_valid = 1'b1; load_addr = 32'h70; load_data = 32'h1;
        step(2'b11, 2'b00, 0, 0, 0, 0, IPC0, IPC1);
        for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 0, 0, 0, 0, IPC0, IPC1);
        for (int i = 0; i < 2; i++) step(2'b01, 2'b00, 0, 0, 0, 0, IPC0, IPC1);
        step(2'b11, 2'b01, 32'h50, 32'h6, 0, 0, FPC, IPC1);
        chk("s5_instr", instr_cnt, 10);
        chk("s5_cycle", cycle_cnt, 6);
        chk("s5_err", err_cnt, 0);
        chk("s5_overrun", overrun, 0);
        chk("s5_pass", pass, 1);

        // Scenario 2: under-consumed trace
        do_reset();
        load3();
        pulse_start(FPC);
        step(0, 0, 0, 0, 0, 0, IPC0, IPC1);
        step(0, 2'b01, 32'h50, 32'h7, 0, 0, IPC0, IPC1);
        step(0, 0, 0, 0, 0, 0, IPC0, IPC1);
        step(0, 2'b10, 0, 0, 32'h54, 32'h8, IPC0, IPC1);
        step(0, 0, 0, 0, 0, 0, FPC, IPC1);
        chk("s2_done", done, 1);
        chk("s2_err", err_cnt, 0);
        chk("s2_pass", pass, 0);

        // Scenario 3: data mismatch and first-error capture
        do_reset();
        load3();
        pulse_start(FPC);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, IPC0, IPC1);
        step(0, 2'b01, 32'h50, 32'h6, 0, 0, IPC0, IPC1);
        chk("s3_err", err_cnt, 1);
        chk("s3_fe_valid", first_err_valid, 1);
        chk("s3_fe_idx", first_err_idx, 0);
        chk("s3_fe_cycle", first_err_cycle, 3);
`ifdef STORE_TRACE_STOP_ON_ERR_EN
        chk("s3_stop_run", run_before, 0);
        chk("s3_stop_done", done, 1);
`else
        chk("s3_run_on", run_before, 1);
        step(0, 2'b01, 32'h54, 32'hFF, 0, 0, IPC0, IPC1);
        chk("s3_err2", err_cnt, 2);
        chk("s3_fe_idx2", first_err_idx, 0);
        chk("s3_fe_cycle2", first_err_cycle, 3);
        step(0, 0, 0, 0, 0, 0, FPC, IPC1);
`endif
        chk("s3_pass", pass, 0);

        // Scenario 4: overrun with a 1-entry trace
        do_reset();
        load(32'h50, 32'h7);
        pulse_start(FPC);
        step(0, 2'b11, 32'h50, 32'h7, 32'h54, 32'h8, IPC0, IPC1);
        chk("s4_overrun", overrun, 1);
        chk("s4_err", err_cnt, 1);
        chk("s4_fe_idx", first_err_idx, 1);
        step(0, 0, 0, 0, 0, 0, FPC, IPC1);
        chk("s4_done", done, 1);
        chk("s4_pass", pass, 0);

        // Full trace: 65th load dropped, 64 entries consumed, extra store overruns
        do_reset();
        for (int i = 0; i < DEPTH; i++) load(32'h1000 + 32'(4*i), 32'(3*i + 1));
        load(32'hDEAD0000, 32'hBAD);
        pulse_start(FPC);
        for (int i = 0; i < DEPTH/2; i++)
            step(0, 2'b11, 32'h1000 + 32'(8*i), 32'(6*i + 1),
                 32'h1004 + 32'(8*i), 32'(6*i + 4), IPC0, IPC1);
        chk("full_err", err_cnt, 0);
        chk("full_overrun0", overrun, 0);
        step(0, 2'b01, 32'h2000, 32'h5, 0, 0, IPC0, IPC1);
        chk("full_overrun1", overrun, 1);
        chk("full_fe_idx", first_err_idx, DEPTH - 1);

        // Mid-run reset clears everything including the trace
        do_reset();
        load3();
        pulse_start(FPC);
        step(0, 2'b01, 32'h50, 32'h1, 0, 0, IPC0, IPC1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mr_cpu_run", cpu_run, 0);
        chk("mr_done", done, 0);
        chk("mr_counts", {cycle_cnt, err_cnt}, 0);
        chk("mr_flags", {overrun, first_err_valid}, 0);
        pulse_start(IPC1);
        step(0, 0, 0, 0, 0, 0, IPC0, IPC1);
        chk("mr_done2", done, 1);
        chk("mr_pass2", pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
